// File: rtl/mem_pkg.sv
// Shared instruction-memory definitions: address width, loader states, header length.
package mem_pkg;
  localparam int IMEM_ADDR_W = 15;
  localparam int HDR_BYTES   = 4;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 assembler; word_vld pulses one cycle after the 4th byte.
// No backpressure: a byte is taken on every in_vld; word_dat holds until the next word.
module byte_packer (
  input  logic        clk,
  input  logic        rstd,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic        in_last,
  output logic        word_vld,
  output logic [31:0] word_dat
);
  logic [1:0]  r_k;
  logic [23:0] r_stage;
  logic [31:0] r_word;
  logic        r_word_vld;

  assign in_last  = in_vld && (r_k == 2'd3);
  assign word_vld = r_word_vld;
  assign word_dat = r_word;

  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_k        <= 2'd0;
      r_stage    <= 24'd0;
      r_word     <= 32'd0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= in_last;
      if (in_vld) begin
        r_k <= r_k + 2'd1;
        // The 4th byte bypasses staging so the word is complete on the next cycle.
        if (in_last) r_word <= {in_dat, r_stage};
        else         r_stage[{r_k, 3'b000} +: 8] <= in_dat;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked byte image into instruction memory; one write per word,
// one cycle after the word's 4th byte. No backpressure: accepts a byte every rx_valid.
module imem_loader
  import mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_rstd
);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(1) << ADDR_W;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_hdr_k;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W:0]   r_wcnt;
  logic [7:0]        r_acc;
  logic [ADDR_W-1:0] r_waddr;

  logic [CNT_W-1:0]  w_n;
  logic [ADDR_W:0]   w_wcnt_inc;
  logic              w_hdr_vld, w_hdr_last, w_pk_vld, w_pk_last, w_last_word;

  assign w_n         = {rx_data, r_cnt[CNT_W-1:8]};
  assign w_hdr_vld   = rx_valid && (r_state == S_HDR);
  assign w_hdr_last  = w_hdr_vld && (r_hdr_k == 2'(HDR_BYTES - 1));
  assign w_pk_vld    = rx_valid && (r_state == S_DATA);
  assign w_wcnt_inc  = r_wcnt + 1'b1;
  // N has already been bounded to 2**ADDR_W, so the low ADDR_W+1 bits are exact.
  assign w_last_word = (w_wcnt_inc == r_cnt[ADDR_W:0]);

  byte_packer u_packer (
    .clk      (clk),
    .rstd     (rstd),
    .in_vld   (w_pk_vld),
    .in_dat   (rx_data),
    .in_last  (w_pk_last),
    .word_vld (we),
    .word_dat (wdata)
  );

  always_ff @(posedge clk) begin
    if (!rstd) r_state <= S_HDR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_hdr_last) begin
          if (w_n > MAX_N)            w_state_nxt = S_ERR;
          else if (w_n == '0)         w_state_nxt = S_SUM;
          else                        w_state_nxt = S_DATA;
        end
      end
      S_DATA:  if (w_pk_last && w_last_word) w_state_nxt = S_SUM;
      S_SUM:   if (rx_valid) w_state_nxt = (rx_data == r_acc) ? S_DONE : S_ERR;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_hdr_k <= 2'd0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_acc   <= 8'd0;
      r_waddr <= '0;
    end else begin
      if (w_hdr_vld) begin
        r_cnt   <= w_n;
        r_hdr_k <= r_hdr_k + 2'd1;
      end
      if (w_pk_vld) r_acc <= r_acc ^ rx_data;
      if (w_pk_last) begin
        r_waddr <= r_wcnt[ADDR_W-1:0];
        r_wcnt  <= w_wcnt_inc;
      end
    end
  end

  assign waddr     = r_waddr;
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign core_rstd = done;
  assign busy      = (r_state == S_DATA) || (r_state == S_SUM) ||
                     ((r_state == S_HDR) && (r_hdr_k != 2'd0));
endmodule
